// File: rtl/challenge_host.sv
// Serial initiator for the key-gated flag device: shifts a 32-bit key in, pulses
// a commit slot with chip-select high, then captures a 256-bit response LSB-first.
module challenge_host #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [31:0]    key,
    output logic           busy,
    output logic           done,
    output logic [255:0]   data,
    output logic           data_valid,
    output logic           dev_clk,
    output logic           dev_cs,
    output logic           dev_i,
    input  logic           dev_o
);

    localparam int unsigned KEY_W  = 32;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SLOT_W = 8;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] KEY_LAST  = SLOT_W'(KEY_W - 1);
    localparam logic [SLOT_W-1:0] READ_LAST = SLOT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_COMMIT,
        S_READ,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [DATA_W-1:0]   data_d;
    logic                clk_d, cs_d, busy_d, done_d, valid_d;
    logic                last_cyc, slot_end;

    // Key register shifts in zeros, so its LSB is already 0 for COMMIT and READ.
    assign dev_i    = key_q[0];
    assign last_cyc = (cnt_q == CNT_LAST);
    assign slot_end = dev_clk && last_cyc;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            slot_q     <= '0;
            key_q      <= '0;
            data       <= '0;
            dev_clk    <= 1'b0;
            dev_cs     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            key_q      <= key_d;
            data       <= data_d;
            dev_clk    <= clk_d;
            dev_cs     <= cs_d;
            busy       <= busy_d;
            done       <= done_d;
            data_valid <= valid_d;
        end
    end

    // Next state; pin values are computed one cycle ahead so every pin is a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        key_d   = key_q;
        data_d  = data;
        clk_d   = dev_clk;
        cs_d    = dev_cs;
        busy_d  = busy;
        done_d  = 1'b0;
        valid_d = data_valid;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KEY;
                    key_d   = key;
                    data_d  = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    clk_d   = 1'b0;
                    cnt_d   = '0;
                    slot_d  = '0;
                end
            end

            S_KEY, S_COMMIT, S_READ: begin
                if (last_cyc) begin
                    cnt_d = '0;
                    clk_d = ~dev_clk;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                // Sample on the last low-phase cycle, before the edge that advances dev_o
                if (state_q == S_READ && !dev_clk && last_cyc) begin
                    data_d = {dev_o, data[DATA_W-1:1]};
                end

                if (slot_end) begin
                    slot_d = slot_q + SLOT_W'(1);
                    case (state_q)
                        S_KEY: begin
                            key_d = {1'b0, key_q[KEY_W-1:1]};
                            if (slot_q == KEY_LAST) begin
                                state_d = S_COMMIT;
                                cs_d    = 1'b1;
                                slot_d  = '0;
                            end
                        end
                        S_COMMIT: begin
                            state_d = S_READ;
                            cs_d    = 1'b0;
                            slot_d  = '0;
                        end
                        default: begin
                            if (slot_q == READ_LAST) begin
                                state_d = S_FINISH;
                                cs_d    = 1'b1;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                valid_d = 1'b1;
                                slot_d  = '0;
                            end
                        end
                    endcase
                end
            end

            S_FINISH: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_challenge_host.sv
// Bench for challenge_host: two instances (CLK_DIV 2 and 1), each with a
// behavioural key-gated flag device, and a scoreboard checked on every done.
module tb_challenge_host;

    localparam logic [31:0]  KEY_OK  = 32'h1337beef;
    localparam logic [31:0]  KEY_BAD = 32'h1337beee;
    localparam logic [255:0] FLAG    =
        256'h666c61677b465047413a204a75737420616c6f74204c555420616e642046467d;

    typedef struct {
        int           inst;
        logic [255:0] data;
        int           cyc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dev_rst = 1'b1;
    logic [1:0]   start_v = '0;
    logic [31:0]  key_v [2];
    logic [1:0]   busy_v, done_v, data_valid_v;
    logic [1:0]   dev_clk_v, dev_cs_v, dev_i_v, dev_o_v;
    logic [255:0] data_v [2];

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned DIV = (g == 0) ? 2 : 1;

        logic [31:0]  kreg = '0;
        logic [255:0] oreg = '0;
        logic         unlocked = 1'b0;
        int           rises = 0;
        int           cs_rises = 0;
        int           viol = 0;
        int           phase_viol = 0;
        int           run = 0;
        logic [7:0]   first8 = '0;
        logic         pclk = 1'b0, pcs = 1'b1, pi = 1'b0, pbusy = 1'b0;

        challenge_host #(.CLK_DIV(DIV)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_v[g]),
            .key        (key_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .data       (data_v[g]),
            .data_valid (data_valid_v[g]),
            .dev_clk    (dev_clk_v[g]),
            .dev_cs     (dev_cs_v[g]),
            .dev_i      (dev_i_v[g]),
            .dev_o      (dev_o_v[g])
        );

        // Device: key shifts in LSB-first; a cs-high edge commits and loads the response
        always @(posedge dev_clk_v[g] or posedge dev_rst) begin
            if (dev_rst) begin
                kreg     <= '0;
                oreg     <= '0;
                unlocked <= 1'b0;
            end else if (dev_cs_v[g]) begin
                if (kreg == KEY_OK) begin
                    unlocked <= 1'b1;
                    oreg     <= FLAG;
                end else begin
                    oreg <= unlocked ? FLAG : '0;
                end
            end else begin
                kreg <= {dev_i_v[g], kreg[31:1]};
                oreg <= {1'b0, oreg[255:1]};
            end
        end
        assign dev_o_v[g] = oreg[0];

        // Pin-level observation: edge counts, setup stability, phase lengths
        always @(negedge clk) begin
            if (dev_clk_v[g] && !pclk) begin
                rises <= rises + 1;
                if (dev_cs_v[g]) cs_rises <= cs_rises + 1;
                if (rises < 8) first8 <= {dev_i_v[g], first8[7:1]};
            end
            if (dev_clk_v[g] && ((dev_cs_v[g] != pcs) || (dev_i_v[g] != pi)))
                viol <= viol + 1;
            if (busy_v[g] && pbusy) begin
                if (dev_clk_v[g] == pclk) begin
                    run <= run + 1;
                end else begin
                    if (run != int'(DIV)) phase_viol <= phase_viol + 1;
                    run <= 1;
                end
            end else if (busy_v[g]) begin
                run <= 1;
            end
            pclk  <= dev_clk_v[g];
            pcs   <= dev_cs_v[g];
            pi    <= dev_i_v[g];
            pbusy <= busy_v[g];
        end
    end

    task automatic start_txn(input int i, input logic [31:0] k, input logic [255:0] exp);
        sb_t e;
        int  div;
        div = (i == 0) ? 2 : 1;
        @(negedge clk);
        start_v[i] = 1'b1;
        key_v[i]   = k;
        e.inst = i;
        e.data = exp;
        e.cyc  = cyc + 1 + 578 * div;
        sb.push_back(e);
        @(negedge clk);
        start_v[i] = 1'b0;
        check("accept_busy", 256'(busy_v[i]), 256'(1));
        check("accept_clr_valid", 256'(data_valid_v[i]), 256'(0));
        check("accept_clr_data", data_v[i], '0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 256'(sb.size()), 256'(0));
    endtask

    task automatic fresh_device();
        @(negedge clk);
        dev_rst = 1'b1;
        @(negedge clk);
        dev_rst = 1'b0;
    endtask

    initial begin
        int r0, c0;
        key_v[0] = '0;
        key_v[1] = '0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        dev_rst = 1'b0;

        fork
            begin : mon
                sb_t e;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < 2; i++) begin
                        if (done_v[i]) begin
                            if (sb.size() == 0) begin
                                check("unexpected_done", 256'(1), 256'(0));
                            end else begin
                                e = sb.pop_front();
                                check("done_inst", 256'(i), 256'(e.inst));
                                check("done_cycle", 256'(cyc), 256'(e.cyc));
                                check("data", data_v[i], e.data);
                                check("data_valid", 256'(data_valid_v[i]), 256'(1));
                                check("busy_low", 256'(busy_v[i]), 256'(0));
                            end
                        end
                    end
                end
            end
        join_none

        // Correct key, CLK_DIV=2, with wire-order checks
        start_txn(0, KEY_OK, FLAG);
        drain(1500);
        check("first8_dev_i", 256'(g_dut[0].first8), 256'(8'hef));
        check("cs_high_edges", 256'(g_dut[0].cs_rises), 256'(1));
        check("total_edges", 256'(g_dut[0].rises), 256'(289));
        check("stable_while_high", 256'(g_dut[0].viol), 256'(0));

        // Wrong key into a never-unlocked device
        fresh_device();
        start_txn(0, KEY_BAD, '0);
        drain(1500);

        // Reset for two cycles mid-KEY
        start_txn(0, KEY_OK, FLAG);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_dev_cs", 256'(dev_cs_v[0]), 256'(1));
        check("rst_dev_clk", 256'(dev_clk_v[0]), 256'(0));
        check("rst_dev_i", 256'(dev_i_v[0]), 256'(0));
        check("rst_busy", 256'(busy_v[0]), 256'(0));
        check("rst_done", 256'(done_v[0]), 256'(0));
        check("rst_valid", 256'(data_valid_v[0]), 256'(0));
        check("rst_data", data_v[0], '0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());

        // start while busy is ignored
        start_txn(0, KEY_OK, FLAG);
        repeat (40) @(negedge clk);
        start_v[0] = 1'b1;
        key_v[0]   = 32'hdeadbeef;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("poke_busy", 256'(busy_v[0]), 256'(1));
        drain(1500);

        // Abort in slot 100, then a fresh transaction
        start_txn(0, KEY_OK, FLAG);
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_dev_cs", 256'(dev_cs_v[0]), 256'(1));
        check("abort_dev_clk", 256'(dev_clk_v[0]), 256'(0));
        check("abort_busy", 256'(busy_v[0]), 256'(0));
        void'(sb.pop_back());
        r0 = g_dut[0].rises;
        repeat (200) @(negedge clk);
        check("abort_no_edges", 256'(g_dut[0].rises - r0), 256'(0));
        start_txn(0, KEY_OK, FLAG);
        drain(1500);

        // CLK_DIV=1 instance
        fresh_device();
        start_txn(1, KEY_OK, FLAG);
        drain(800);
        c0 = g_dut[1].cs_rises;
        check("div1_cs_high_edges", 256'(c0), 256'(1));
        check("div1_phase_len", 256'(g_dut[1].phase_viol), 256'(0));
        check("div2_phase_len", 256'(g_dut[0].phase_viol), 256'(0));
        check("div1_stable", 256'(g_dut[1].viol), 256'(0));
        check("div2_stable", 256'(g_dut[0].viol), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/challenge_host.md
# challenge_host

Serial initiator that drives the key-gated flag device over its four-wire interface (`dev_clk`, `dev_cs`, `dev_i`, `dev_o`).
- On a start request it shifts a 32-bit key into the device LSB-first, raises chip-select for one commit clock, then clocks out and captures a 256-bit response LSB-first.
- Sits between a host-side command register and the device pins; all device-facing outputs are registered and generated from the single system clock.

## Interface
- `CLK_DIV`, 2, system cycles per `dev_clk` half-period; legal range 1..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only when `busy`=0.
- `key`  in  32  key value; sampled on the cycle `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse at end of transaction.
- `data`  out  256  captured response; `data[k]` is the k-th bit sampled.
- `data_valid`  out  1  high from `done` until next accepted `start` or reset.
- `dev_clk`  out  1  serial clock to device; device acts on its rising edge.
- `dev_cs`  out  1  chip select, active low.
- `dev_i`  out  1  serial data to device.
- `dev_o`  in  1  serial data from device.

## Operation
- Transaction is 289 bit slots, in this order:
  - KEY: slots 0..31, `dev_cs`=0, `dev_i`=key[n] for slot n.
  - COMMIT: slot 32, `dev_cs`=1, `dev_i`=0.
  - READ: slots 33..288, `dev_cs`=0, `dev_i`=0.
- States: IDLE, KEY, COMMIT, READ, FINISH. Transitions:
  - IDLE→KEY on accepted `start`.
  - KEY→COMMIT after slot 31.
  - COMMIT→READ after one slot.
  - READ→FINISH after 256 slots.
  - FINISH→IDLE in one cycle, pulsing `done`.
- Key is held in a 32-bit shift register, shifted right once per KEY slot.
- READ capture: on the last system cycle of each slot's low phase, register `dev_o` into `data[k]`, k = READ slot index 0..255. `data` fills via a right shift with `dev_o` entering bit 255, so after 256 slots `data[0]` holds the first sample.
- A correct key yields the device's stored 256-bit value. A wrong key into a never-unlocked device yields all zeros.
- `start` while `busy`=1 is ignored with no effect.
- `data` and `data_valid` are cleared on accepted `start`.
- Reset values: `dev_clk`=0, `dev_cs`=1, `dev_i`=0, `busy`=0, `done`=0, `data_valid`=0, `data`=0, state IDLE.
- In IDLE and FINISH: `dev_cs`=1, `dev_clk`=0, and no `dev_clk` rising edge is produced. A stray edge with cs high would reload the device.
- Reset mid-transaction: abort at once. Next cycle shows reset values, including `dev_cs`=1 and `dev_clk`=0. The device keeps whatever it had received; the host does not clean up.

## Timing
- Slot = CLK_DIV cycles with `dev_clk`=0 (low phase), then CLK_DIV cycles with `dev_clk`=1 (high phase). Slot length = 2·CLK_DIV cycles.
- `dev_cs` and `dev_i` change only on the first cycle of a low phase, so they are stable for ≥CLK_DIV cycles before each `dev_clk` rising edge.
- `dev_o` is sampled ≥1 cycle before the rising edge that advances it.
- If `start` is accepted at edge T:
  - `busy`=1 and slot 0's low phase begin at T+1.
  - `done` is high during cycle T+1+578·CLK_DIV.
  - `busy` falls and `data_valid` rises in that same cycle.
- Back-to-back: a `start` in the `done` cycle is ignored; the earliest accept is the following cycle.
- All outputs are registered, with no combinational path from `dev_o` or `start` to any output.

## Test plan
- Reset: assert `rst` 2 cycles mid-KEY → next cycle `dev_cs`=1, `dev_clk`=0, `dev_i`=0, `busy`=0, `done`=0, `data_valid`=0, `data`=0.
- Correct key, CLK_DIV=2, behavioural device model attached: `key`=32'h1337beef → `done` 1157 cycles after accept; `data`=256'h666c61677b465047413a204a75737420616c6f74204c555420616e642046467d; `data_valid`=1.
- Wire order: same run, `dev_i` at the first 8 `dev_clk` rising edges = 1,1,1,1,0,1,1,1 (0xef LSB-first). Exactly one rising edge with `dev_cs`=1 (slot 32). `dev_cs`/`dev_i` never change while `dev_clk`=1.
- Wrong key on a fresh device model: `key`=32'h1337beee → `data`=0, `done` at the same cycle count.
- Busy/abort: pulse `start` at slot 10 with a different key → ignored, result unchanged. Then assert `rst` in slot 100 → no further `dev_clk` edges. Fresh start with the correct key completes with the flag value.
- CLK_DIV=1: correct key → `done` 579 cycles after accept, `data` equals the flag value; each `dev_clk` high and low phase lasts exactly 1 cycle.
